// File: rtl/router_fifo_pkt.sv
// Packet-aware output-channel FIFO: stores {header tag, data} per entry and
// follows packet boundaries on the read side using the header length field.
module router_fifo_pkt #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int LEN_LSB   = 2,
    parameter int AF_THRESH = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   occupancy,
    output logic              pkt_active,
    output logic              pkt_last,
    output logic              overflow,
    output logic              underflow,
    output logic              pkt_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LEN_W = DATA_W - LEN_LSB;
    localparam int REM_W = LEN_W + 1;

    logic [DATA_W:0]     mem_q [DEPTH];

    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                pkt_last_q, pkt_last_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                pkt_err_q, pkt_err_d;

    logic                wr_acc, rd_acc, flush;
    logic [DATA_W:0]     rd_entry;
    logic                rd_tag;
    logic [LEN_W-1:0]    rd_len;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                         (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign almost_full = (occupancy >= (ADDR_W+1)'(AF_THRESH));

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign pkt_last    = pkt_last_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign pkt_err     = pkt_err_q;
    assign pkt_active  = (rem_q != '0);

    assign flush    = reset || soft_reset;
    assign wr_acc   = write_enb && !full;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign rd_tag   = rd_entry[DATA_W];
    assign rd_len   = rd_entry[DATA_W-1:LEN_LSB];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rem_d        = rem_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        pkt_last_d   = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        pkt_err_d    = pkt_err_q;

        if (wr_acc)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (write_enb && full)
            overflow_d = 1'b1;
        if (read_enb && empty)
            underflow_d = 1'b1;

        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            data_out_d   = rd_entry[DATA_W-1:0];
            data_valid_d = 1'b1;
            if (rd_tag) begin
                // A header arriving while bytes are still owed means the previous packet was cut short.
                if (rem_q != '0)
                    pkt_err_d = 1'b1;
                rem_d = {1'b0, rd_len} + REM_W'(1);
            end else if (rem_q != '0) begin
                rem_d = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1))
                    pkt_last_d = 1'b1;
            end else begin
                pkt_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rem_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            pkt_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            pkt_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rem_q        <= rem_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            pkt_last_q   <= pkt_last_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            pkt_err_q    <= pkt_err_d;
        end
    end

    // Storage is deliberately not cleared by either reset.
    always_ff @(posedge clock) begin
        if (!flush && wr_acc)
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_state, data_in};
    end

endmodule
